// File: rtl/pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_pkg : shared types and constants for pipeline stage registers |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package pipe_pkg;

   // Encoding doubles as the held-entry count driven on occupancy_o.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } stage_state_e;

   localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage
`default_nettype wire

// File: rtl/pipe_stage_skid_sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sat_counter : saturating event counter, cleared only by reset      |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (inc_i && (cnt_q != {W{1'b1}})) begin
         cnt_q <= cnt_q + W'(1);
      end
   end

   assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_stage_skid : handshaked pipeline register with skid entry,    |
// |                   flush-to-bubble and bubble-cycle counter         |
// | Revision        : 1.0                                              |
// +--------------------------------------------------------------------+
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int              DATA_W  = 32,
   parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}},
   parameter bit              SKID_EN = 1'b1,
   parameter int              CNT_W   = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   input  logic              stall_i,
   input  logic              flush_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [1:0]        occupancy_o,
   output logic [CNT_W-1:0]  bubble_cnt_o
);

   stage_state_e      state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              w_ready;
   logic              w_acc;
   logic              w_cons;

   assign out_valid_o = (state_q != ST_EMPTY);
   assign w_cons      = out_valid_o & out_ready_i & ~stall_i;

   generate
      if (SKID_EN) begin : g_skid
         assign w_ready = (state_q != ST_SKID);
      end else begin : g_noskid
         // Single entry: accept only when it is free or being drained now.
         assign w_ready = (state_q == ST_EMPTY) | w_cons;
      end
   endgenerate

   assign in_ready_o = ~rst_i & w_ready;
   assign w_acc      = in_valid_i & in_ready_o;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush_i) begin
         state_d = ST_EMPTY;
         main_d  = BUBBLE;
         skid_d  = BUBBLE;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (w_acc) begin
                  state_d = ST_FULL;
                  main_d  = in_data_i;
               end
            end
            ST_FULL: begin
               if (w_acc && w_cons) begin
                  main_d = in_data_i;
               end else if (w_acc) begin
                  state_d = ST_SKID;
                  skid_d  = in_data_i;
               end else if (w_cons) begin
                  state_d = ST_EMPTY;
                  main_d  = BUBBLE;
               end
            end
            ST_SKID: begin
               if (w_cons) begin
                  state_d = ST_FULL;
                  main_d  = skid_q;
                  skid_d  = BUBBLE;
               end
            end
            default: begin
               state_d = ST_EMPTY;
               main_d  = BUBBLE;
               skid_d  = BUBBLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_EMPTY;
         main_q  <= BUBBLE;
         skid_q  <= BUBBLE;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   // main_q is kept at BUBBLE whenever the stage is empty.
   assign out_data_o  = main_q;
   assign occupancy_o = 2'(state_q);

   sat_counter #(
      .W (CNT_W)
   ) u_bubble_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (~out_valid_o),
      .cnt_o (bubble_cnt_o)
   );

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pipe_stage_skid : scoreboard bench, skid and no-skid instances  |
// | Revision           : 1.0                                           |
// +--------------------------------------------------------------------+
module tb_pipe_stage_skid;

   localparam logic [31:0] BUB = 32'h0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        out_ready = 1'b1;

   logic        rdy0, vld0, rdy1, vld1;
   logic [31:0] dat0, dat1;
   logic [1:0]  occ0, occ1;
   logic [3:0]  cnt0, cnt1;

   always #5 clk = ~clk;

   pipe_stage_skid #(.DATA_W(32), .BUBBLE(BUB), .SKID_EN(1'b1), .CNT_W(4)) dut0 (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy0),
      .in_data_i(in_data), .stall_i(stall), .flush_i(flush),
      .out_valid_o(vld0), .out_ready_i(out_ready), .out_data_o(dat0),
      .occupancy_o(occ0), .bubble_cnt_o(cnt0));

   pipe_stage_skid #(.DATA_W(32), .BUBBLE(BUB), .SKID_EN(1'b0), .CNT_W(4)) dut1 (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy1),
      .in_data_i(in_data), .stall_i(stall), .flush_i(flush),
      .out_valid_o(vld1), .out_ready_i(out_ready), .out_data_o(dat1),
      .occupancy_o(occ1), .bubble_cnt_o(cnt1));

   typedef struct {
      bit          chk;
      logic        v;
      logic [31:0] d;
      logic [1:0]  occ;
      logic        rdy;
      logic [3:0]  cnt;
   } exp_t;

   exp_t        eq0[$], eq1[$];
   logic [31:0] dq0[$], dq1[$];

   // Reference model: each stage is a bounded FIFO of held beats.
   logic [31:0] ent[2][2];
   int          nheld[2];
   int          bcnt[2];
   bit          first = 1'b1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic cmp(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s dut%0d t=%0t: got %h expected %h", nm, k, $time, act, exp);
      end
   endtask

   task automatic model_step(input int k);
      exp_t e;
      logic cons, rdy, acc;
      int   cap;
      cap   = (k == 0) ? 2 : 1;
      e.chk = !first;
      e.v   = (nheld[k] > 0);
      e.d   = e.v ? ent[k][0] : BUB;
      e.occ = 2'(nheld[k]);
      e.cnt = 4'(bcnt[k]);
      cons  = e.v && out_ready && !stall;
      if (rst)          rdy = 1'b0;
      else if (k == 0)  rdy = (nheld[k] < cap);
      else              rdy = (nheld[k] == 0) || cons;
      e.rdy = rdy;
      acc   = in_valid && rdy;
      if (k == 0) eq0.push_back(e); else eq1.push_back(e);
      if (cons && !first) begin
         if (k == 0) dq0.push_back(ent[k][0]); else dq1.push_back(ent[k][0]);
      end
      if (rst) begin
         nheld[k] = 0;
         bcnt[k]  = 0;
      end else begin
         if (!e.v && bcnt[k] < 15) bcnt[k]++;
         if (flush) begin
            nheld[k] = 0;
         end else begin
            if (cons) begin
               ent[k][0] = ent[k][1];
               nheld[k]--;
            end
            if (acc) begin
               ent[k][nheld[k]] = in_data;
               nheld[k]++;
            end
         end
      end
   endtask

   task automatic cycle(input logic r, input logic v, input logic [31:0] d,
                        input logic st, input logic fl, input logic rd);
      @(negedge clk);
      rst = r; in_valid = v; in_data = d; stall = st; flush = fl; out_ready = rd;
      #1;
      model_step(0);
      model_step(1);
      first = 1'b0;
   endtask

   task automatic check_one(input int k, input exp_t e, input logic v, input logic rdy,
                            input logic [31:0] d, input logic [1:0] occ, input logic [3:0] c);
      logic [31:0] want;
      if (!e.chk) return;
      cmp("out_valid", k, 32'(v), 32'(e.v));
      cmp("out_data", k, d, e.d);
      cmp("occupancy", k, 32'(occ), 32'(e.occ));
      cmp("in_ready", k, 32'(rdy), 32'(e.rdy));
      cmp("bubble_cnt", k, 32'(c), 32'(e.cnt));
      if (v && out_ready && !stall) begin
         if ((k == 0 && dq0.size() == 0) || (k == 1 && dq1.size() == 0)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL delivery dut%0d t=%0t: got beat %h expected none", k, $time, d);
         end else begin
            want = (k == 0) ? dq0.pop_front() : dq1.pop_front();
            cmp("delivered", k, d, want);
         end
      end
   endtask

   // Monitor: pops the expectations queued by the stimulus side.
   always @(negedge clk) begin
      #2;
      if (eq0.size() > 0) check_one(0, eq0.pop_front(), vld0, rdy0, dat0, occ0, cnt0);
      if (eq1.size() > 0) check_one(1, eq1.pop_front(), vld1, rdy1, dat1, occ1, cnt1);
   end

   initial begin
      nheld = '{0, 0};
      bcnt  = '{0, 0};
      // Reset with a beat offered: it must be dropped.
      cycle(1, 1, 32'hAA, 0, 0, 1);
      cycle(1, 1, 32'hAA, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 1);
      // Streaming.
      cycle(0, 1, 32'h11, 0, 0, 1);
      cycle(0, 1, 32'h22, 0, 0, 1);
      cycle(0, 1, 32'h33, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 1);
      // Backpressure into the skid entry.
      cycle(0, 1, 32'h11, 0, 0, 1);
      cycle(0, 1, 32'h22, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 1);
      // Flush while full of skid, stalled, with a beat offered.
      cycle(0, 1, 32'h44, 0, 0, 0);
      cycle(0, 1, 32'h55, 0, 0, 0);
      cycle(0, 1, 32'h66, 1, 1, 1);
      cycle(0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 1);
      // Counter saturation.
      cycle(1, 0, 0, 0, 0, 1);
      for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 0, 1);
      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom_range(99) < 2), ($urandom_range(99) < 70), $urandom,
               ($urandom_range(99) < 10), ($urandom_range(99) < 5),
               ($urandom_range(99) < 70));
      end
      cycle(0, 0, 0, 0, 1, 1);
      cycle(0, 0, 0, 0, 0, 1);
      @(negedge clk);
      #4;
      cmp("leftover_beats", 0, 32'(dq0.size()), 32'd0);
      cmp("leftover_beats", 1, 32'(dq1.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
